// File: rtl/tea_pkg.sv
// Shared definitions for the TEA datapath: word size, loader state codes and frame lengths.
// TEA_DELTA lives here so the loader and the cipher agree on one constant.
package tea_pkg;

  localparam int DEFAULT_WORD_SIZE = 32;
  localparam int KEY_FRAME_WORDS   = 6;
  localparam int DATA_FRAME_WORDS  = 2;
  localparam int KEY_WORDS         = KEY_FRAME_WORDS - DATA_FRAME_WORDS;

  localparam logic [31:0] TEA_DELTA = 32'h9e3779b9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KEY   = 3'd1,
    ST_DATA  = 3'd2,
    ST_OUT   = 3'd3,
    ST_DRAIN = 3'd4
  } loader_state_t;

endpackage

// File: rtl/tea_block_loader.sv
// Collects a framed word stream into one TEA block (v0,v1) plus optional key (k0..k3)
// and presents it to the cipher under a valid/ready handshake.
module tea_block_loader
  import tea_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_first,
  input  logic                 in_key,
  input  logic                 in_last,
  output logic [WORD_SIZE-1:0] v0,
  output logic [WORD_SIZE-1:0] v1,
  output logic [WORD_SIZE-1:0] k0,
  output logic [WORD_SIZE-1:0] k1,
  output logic [WORD_SIZE-1:0] k2,
  output logic [WORD_SIZE-1:0] k3,
  output logic                 blk_valid,
  input  logic                 blk_ready,
  output logic                 key_ok,
  output logic                 err,
  output logic [CNT_WIDTH-1:0] blk_cnt
);

  localparam logic [2:0] KEY_WORDS_W = 3'(KEY_WORDS);

  loader_state_t        state_reg, state_next;
  logic [2:0]           cnt_reg, cnt_next;
  logic                 key_frame_reg, key_frame_next;
  logic [WORD_SIZE-1:0] sk_reg [KEY_WORDS];
  logic [WORD_SIZE-1:0] sk_next [KEY_WORDS];
  logic [WORD_SIZE-1:0] sv0_reg, sv0_next;
  logic [WORD_SIZE-1:0] v0_reg, v0_next, v1_reg, v1_next;
  logic [WORD_SIZE-1:0] k_reg [KEY_WORDS];
  logic [WORD_SIZE-1:0] k_next [KEY_WORDS];
  logic                 key_ok_reg, key_ok_next;
  logic                 blk_valid_reg, blk_valid_next;
  logic                 err_reg, err_next;
  logic [CNT_WIDTH-1:0] blk_cnt_reg, blk_cnt_next;
  logic                 xfer;
  logic                 start_frame;

  assign in_ready = (state_reg != ST_OUT);
  assign xfer     = in_valid & in_ready;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    key_frame_next = key_frame_reg;
    sk_next        = sk_reg;
    sv0_next       = sv0_reg;
    v0_next        = v0_reg;
    v1_next        = v1_reg;
    k_next         = k_reg;
    key_ok_next    = key_ok_reg;
    blk_valid_next = blk_valid_reg;
    blk_cnt_next   = blk_cnt_reg;
    err_next       = 1'b0;
    start_frame    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (xfer) start_frame = 1'b1;
      end
      ST_KEY: begin
        if (xfer) begin
          if (in_first) begin
            err_next    = 1'b1;
            start_frame = 1'b1;
          end else if (in_last) begin
            err_next   = 1'b1;
            state_next = ST_IDLE;
          end else if (cnt_reg < KEY_WORDS_W) begin
            sk_next[cnt_reg[1:0]] = in_data;
            cnt_next              = cnt_reg + 3'd1;
          end else begin
            sv0_next   = in_data;
            state_next = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (xfer) begin
          if (in_first) begin
            err_next    = 1'b1;
            start_frame = 1'b1;
          end else if (in_last) begin
            // The final word goes straight to v1; no need to shadow it.
            v0_next = sv0_reg;
            v1_next = in_data;
            if (key_frame_reg) begin
              k_next      = sk_reg;
              key_ok_next = 1'b1;
            end
            blk_valid_next = 1'b1;
            state_next     = ST_OUT;
          end else begin
            err_next   = 1'b1;
            state_next = ST_DRAIN;
          end
        end
      end
      ST_OUT: begin
        if (blk_ready) begin
          blk_valid_next = 1'b0;
          blk_cnt_next   = blk_cnt_reg + CNT_WIDTH'(1);
          state_next     = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (xfer && in_last) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // First-word handling, shared by IDLE and by a mid-frame restart on in_first.
    if (start_frame) begin
      if (!in_first) begin
        err_next   = 1'b1;
        state_next = in_last ? ST_IDLE : ST_DRAIN;
      end else if (in_last) begin
        err_next   = 1'b1;
        state_next = ST_IDLE;
      end else if (in_key) begin
        sk_next[0]     = in_data;
        cnt_next       = 3'd1;
        key_frame_next = 1'b1;
        state_next     = ST_KEY;
      end else if (key_ok_reg) begin
        sv0_next       = in_data;
        key_frame_next = 1'b0;
        state_next     = ST_DATA;
      end else begin
        err_next   = 1'b1;
        state_next = ST_DRAIN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      key_frame_reg <= 1'b0;
      sv0_reg       <= '0;
      v0_reg        <= '0;
      v1_reg        <= '0;
      key_ok_reg    <= 1'b0;
      blk_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
      blk_cnt_reg   <= '0;
      for (int i = 0; i < KEY_WORDS; i++) begin
        sk_reg[i] <= '0;
        k_reg[i]  <= '0;
      end
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      key_frame_reg <= key_frame_next;
      sv0_reg       <= sv0_next;
      v0_reg        <= v0_next;
      v1_reg        <= v1_next;
      key_ok_reg    <= key_ok_next;
      blk_valid_reg <= blk_valid_next;
      err_reg       <= err_next;
      blk_cnt_reg   <= blk_cnt_next;
      for (int i = 0; i < KEY_WORDS; i++) begin
        sk_reg[i] <= sk_next[i];
        k_reg[i]  <= k_next[i];
      end
    end
  end

  assign v0        = v0_reg;
  assign v1        = v1_reg;
  assign k0        = k_reg[0];
  assign k1        = k_reg[1];
  assign k2        = k_reg[2];
  assign k3        = k_reg[3];
  assign key_ok    = key_ok_reg;
  assign blk_valid = blk_valid_reg;
  assign err       = err_reg;
  assign blk_cnt   = blk_cnt_reg;

endmodule

// File: tb/tb_tea_block_loader.sv
// Directed self-checking bench for tea_block_loader: framing, key retention, handshake stall,
// async reset mid-frame and block-counter wrap (counter narrowed so the wrap is reachable).
module tb_tea_block_loader;

  localparam int WS = 32;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [WS-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_first = 1'b0;
  logic          in_key = 1'b0;
  logic          in_last = 1'b0;
  logic [WS-1:0] v0, v1, k0, k1, k2, k3;
  logic          blk_valid;
  logic          blk_ready = 1'b0;
  logic          key_ok;
  logic          err;
  logic [CW-1:0] blk_cnt;

  int checks = 0;
  int errors = 0;
  logic last_err;

  tea_block_loader #(.WORD_SIZE(WS), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_key(in_key), .in_last(in_last),
    .v0(v0), .v1(v1), .k0(k0), .k1(k1), .k2(k2), .k3(k3),
    .blk_valid(blk_valid), .blk_ready(blk_ready),
    .key_ok(key_ok), .err(err), .blk_cnt(blk_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One word transfer; waits (bounded) for in_ready, returns err as seen after the edge.
  task automatic send(input logic [WS-1:0] w, input logic f, input logic k, input logic l,
                      output logic e);
    int guard;
    guard = 0;
    @(negedge clk);
    in_data = w; in_first = f; in_key = k; in_last = l; in_valid = 1'b1;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_first = 1'b0; in_key = 1'b0; in_last = 1'b0;
    e = err;
    $display("word %h first=%0b key=%0b last=%0b -> err=%0b blk_valid=%0b", w, f, k, l, e, blk_valid);
  endtask

  task automatic handoff();
    @(negedge clk);
    blk_ready = 1'b1;
    @(posedge clk);
    #1;
    blk_ready = 1'b0;
    $display("handoff -> blk_valid=%0b blk_cnt=%0d", blk_valid, blk_cnt);
  endtask

  task automatic send_key_frame();
    send(32'h00010203, 1, 1, 0, last_err);
    send(32'h04050607, 0, 0, 0, last_err);
    send(32'h08090a0b, 0, 0, 0, last_err);
    send(32'h0c0d0e0f, 0, 0, 0, last_err);
    send(32'h01234567, 0, 0, 0, last_err);
    send(32'h89abcdef, 0, 0, 1, last_err);
  endtask

  initial begin
    logic [WS-1:0] held_v0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_blk_valid", {63'd0, blk_valid}, 64'd0);
    check("rst_key_ok", {63'd0, key_ok}, 64'd0);
    check("rst_blk_cnt", {56'd0, blk_cnt}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_v0", {32'd0, v0}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Test 3: data frame before any key
    send(32'h11111111, 1, 0, 0, last_err);
    check("nokey_err", {63'd0, last_err}, 64'd1);
    send(32'h22222222, 0, 0, 1, last_err);
    check("nokey_drain_err", {63'd0, last_err}, 64'd0);
    check("nokey_blk_valid", {63'd0, blk_valid}, 64'd0);
    check("nokey_key_ok", {63'd0, key_ok}, 64'd0);

    // Test 1: full key frame
    send_key_frame();
    check("key_err", {63'd0, last_err}, 64'd0);
    check("key_blk_valid", {63'd0, blk_valid}, 64'd1);
    check("key_k0", {32'd0, k0}, 64'h00010203);
    check("key_k3", {32'd0, k3}, 64'h0c0d0e0f);
    check("key_v0", {32'd0, v0}, 64'h01234567);
    check("key_v1", {32'd0, v1}, 64'h89abcdef);
    check("key_key_ok", {63'd0, key_ok}, 64'd1);
    check("key_in_ready", {63'd0, in_ready}, 64'd0);
    handoff();
    check("key_cnt", {56'd0, blk_cnt}, 64'd1);
    check("key_valid_drop", {63'd0, blk_valid}, 64'd0);

    // Test 2: data frame reuses key
    send(32'h11111111, 1, 0, 0, last_err);
    send(32'h22222222, 0, 0, 1, last_err);
    check("data_v0", {32'd0, v0}, 64'h11111111);
    check("data_v1", {32'd0, v1}, 64'h22222222);
    check("data_k0", {32'd0, k0}, 64'h00010203);
    check("data_k2", {32'd0, k2}, 64'h08090a0b);
    handoff();
    check("data_cnt", {56'd0, blk_cnt}, 64'd2);

    // Test 4: early in_last on word 3 of a key frame
    send(32'haaaa0000, 1, 1, 0, last_err);
    send(32'hbbbb0000, 0, 0, 0, last_err);
    send(32'hcccc0000, 0, 0, 1, last_err);
    check("early_err", {63'd0, last_err}, 64'd1);
    check("early_blk_valid", {63'd0, blk_valid}, 64'd0);
    check("early_k0", {32'd0, k0}, 64'h00010203);
    check("early_k1", {32'd0, k1}, 64'h04050607);
    send(32'h33333333, 1, 0, 0, last_err);
    send(32'h44444444, 0, 0, 1, last_err);
    check("after_early_v0", {32'd0, v0}, 64'h33333333);
    check("after_early_valid", {63'd0, blk_valid}, 64'd1);
    check("after_early_k1", {32'd0, k1}, 64'h04050607);
    handoff();
    check("after_early_cnt", {56'd0, blk_cnt}, 64'd3);

    // in_first mid-frame restarts with that word
    send(32'h55555555, 1, 0, 0, last_err);
    send(32'h66666666, 1, 0, 0, last_err);
    check("restart_err", {63'd0, last_err}, 64'd1);
    send(32'h77777777, 0, 0, 1, last_err);
    check("restart_v0", {32'd0, v0}, 64'h66666666);
    check("restart_v1", {32'd0, v1}, 64'h77777777);
    handoff();

    // Missing in_last on final word -> err, drain
    send(32'h5a5a5a5a, 1, 0, 0, last_err);
    send(32'ha5a5a5a5, 0, 0, 0, last_err);
    check("nolast_err", {63'd0, last_err}, 64'd1);
    send(32'hdeadbeef, 0, 0, 1, last_err);
    check("nolast_blk_valid", {63'd0, blk_valid}, 64'd0);
    check("nolast_v0", {32'd0, v0}, 64'h66666666);

    // Test 5: stall while in_valid is high
    send(32'h88888888, 1, 0, 0, last_err);
    send(32'h99999999, 0, 0, 1, last_err);
    held_v0 = v0;
    check("stall_start_v0", {32'd0, held_v0}, 64'h88888888);
    @(negedge clk);
    in_data = 32'h12345678; in_first = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_in_ready", {63'd0, in_ready}, 64'd0);
      check("stall_v0", {32'd0, v0}, {32'd0, held_v0});
      check("stall_valid", {63'd0, blk_valid}, 64'd1);
    end
    blk_ready = 1'b1;
    @(posedge clk);
    #1;
    blk_ready = 1'b0;
    check("stall_release_cnt", {56'd0, blk_cnt}, 64'd5);
    check("stall_release_valid", {63'd0, blk_valid}, 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_first = 1'b0;
    check("stall_word_err", {63'd0, err}, 64'd0);
    send(32'h9abcdef0, 0, 0, 1, last_err);
    check("stall_next_v0", {32'd0, v0}, 64'h12345678);
    check("stall_next_v1", {32'd0, v1}, 64'h9abcdef0);
    handoff();
    check("stall_next_cnt", {56'd0, blk_cnt}, 64'd6);

    // Test 6: async reset mid key frame, then counter wrap
    send(32'hf0000000, 1, 1, 0, last_err);
    send(32'hf1111111, 0, 0, 0, last_err);
    send(32'hf2222222, 0, 0, 0, last_err);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_cnt", {56'd0, blk_cnt}, 64'd0);
    check("midrst_key_ok", {63'd0, key_ok}, 64'd0);
    check("midrst_k0", {32'd0, k0}, 64'd0);
    check("midrst_v1", {32'd0, v1}, 64'd0);
    check("midrst_valid", {63'd0, blk_valid}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    send(32'h0badf00d, 0, 0, 0, last_err);
    check("postrst_drop_err", {63'd0, last_err}, 64'd1);
    send(32'h0badf00e, 0, 0, 1, last_err);
    send_key_frame();
    handoff();
    check("wrap_first_cnt", {56'd0, blk_cnt}, 64'd1);
    for (int i = 0; i < 254; i++) begin
      send(i, 1, 0, 0, last_err);
      send(~i, 0, 0, 1, last_err);
      handoff();
    end
    check("wrap_max_cnt", {56'd0, blk_cnt}, 64'hff);
    send(32'hcafef00d, 1, 0, 0, last_err);
    send(32'h00c0ffee, 0, 0, 1, last_err);
    handoff();
    check("wrap_zero_cnt", {56'd0, blk_cnt}, 64'h00);
    check("wrap_k3", {32'd0, k3}, 64'h0c0d0e0f);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
